// File: rtl/shift_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_sched_pkg
// Brief   : Shared constants and state encoding for the shift scheduler.
// Revision: 1.0
// ============================================================================
package shift_sched_pkg;

  localparam int c_data_w  = 32;
  localparam int c_shamt_w = 5;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_pass1 = 2'd1;
  localparam logic [1:0] c_st_pass2 = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = c_st_idle,
    S_PASS1 = c_st_pass1,
    S_PASS2 = c_st_pass2,
    S_RESP  = c_st_resp
  } state_t;

  // Complementary amount for the second half of a rotate: (32 - s) mod 32.
  function automatic logic [c_shamt_w-1:0] neg_shamt(input logic [c_shamt_w-1:0] s);
    logic [c_shamt_w-1:0] r;
    r = '0 - s;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sched_rr.sv
`default_nettype none
// ============================================================================
// Module  : shift_sched_rr
// Brief   : Combinational round-robin picker; search starts at ptr.
// Revision: 1.0
// ============================================================================
module shift_sched_rr #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic w_found;

  // Two sweeps: indices at/after ptr first, then the wrapped-around ones.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any     = |req;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[i] && (i >= int'(ptr))) begin
        gnt[i]  = 1'b1;
        idx     = IDW'(i);
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[i]) begin
        gnt[i]  = 1'b1;
        idx     = IDW'(i);
        w_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_sched.sv
`default_nettype none
// ============================================================================
// Module  : shift_sched
// Brief   : Round-robin sharing of one external barrel shifter among NREQ
//           requesters. Define SHIFT_SCHED_ROTATE_EN to build two-pass rotate.
// Revision: 1.0
// ============================================================================
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*c_data_w-1:0] req_x,
  input  logic [NREQ*c_shamt_w-1:0] req_s,
  input  logic [NREQ-1:0]          req_left,
  input  logic [NREQ-1:0]          req_log,
  input  logic [NREQ-1:0]          req_rot,
  output logic [c_data_w-1:0]      sh_x,
  output logic [c_shamt_w-1:0]     sh_s,
  output logic                     sh_left,
  output logic                     sh_log,
  output logic                     sh_en,
  input  logic [c_data_w-1:0]      sh_z,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [c_data_w-1:0]      rsp_z,
  output logic [IDW-1:0]           rsp_id
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDW-1:0]        r_ptr;
  logic [c_data_w-1:0]   r_x;
  logic [c_data_w-1:0]   r_acc;
  logic [c_shamt_w-1:0]  r_s;
  logic                  r_left;
  logic                  r_log;
  logic [IDW-1:0]        r_id;
  logic                  w_rot_op;

  logic [NREQ-1:0]       w_gnt;
  logic [IDW-1:0]        w_idx;
  logic                  w_any;

  logic [c_data_w-1:0]   w_x_arr [NREQ];
  logic [c_shamt_w-1:0]  w_s_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_x_arr[gi] = req_x[gi*c_data_w +: c_data_w];
      assign w_s_arr[gi] = req_s[gi*c_shamt_w +: c_shamt_w];
    end
  endgenerate

  shift_sched_rr #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

`ifdef SHIFT_SCHED_ROTATE_EN
  logic r_rot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rot <= 1'b0;
    end else if (r_state == S_IDLE && w_any) begin
      r_rot <= req_rot[w_idx];
    end
  end

  assign w_rot_op = r_rot;
`else
  logic w_unused_rot;
  assign w_unused_rot = ^req_rot;
  assign w_rot_op     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    sh_en       = 1'b0;
    sh_s        = r_s;
    sh_left     = r_left;
    sh_log      = r_log;
    rsp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = w_gnt;
        if (w_any) begin
          w_state_nxt = S_PASS1;
        end
      end
      S_PASS1: begin
        sh_en = 1'b1;
        // A rotate's first pass must not sign-extend.
        if (w_rot_op) begin
          sh_log = 1'b1;
        end
`ifdef SHIFT_SCHED_ROTATE_EN
        w_state_nxt = (w_rot_op && (r_s != '0)) ? S_PASS2 : S_RESP;
`else
        w_state_nxt = S_RESP;
`endif
      end
`ifdef SHIFT_SCHED_ROTATE_EN
      S_PASS2: begin
        sh_en       = 1'b1;
        sh_s        = neg_shamt(r_s);
        sh_left     = ~r_left;
        sh_log      = 1'b1;
        w_state_nxt = S_RESP;
      end
`endif
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_x    <= '0;
      r_s    <= '0;
      r_left <= 1'b0;
      r_log  <= 1'b0;
      r_id   <= '0;
      r_acc  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_x    <= w_x_arr[w_idx];
        r_s    <= w_s_arr[w_idx];
        r_left <= req_left[w_idx];
        r_log  <= req_log[w_idx];
        r_id   <= w_idx;
        r_ptr  <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + IDW'(1);
      end
      if (r_state == S_PASS1) begin
        r_acc <= sh_z;
      end
`ifdef SHIFT_SCHED_ROTATE_EN
      // Second pass supplies the bits that wrapped around.
      if (r_state == S_PASS2) begin
        r_acc <= r_acc | sh_z;
      end
`endif
    end
  end

  assign sh_x   = r_x;
  assign rsp_z  = r_acc;
  assign rsp_id = r_id;

endmodule
`default_nettype wire

// File: tb/tb_shift_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_sched
// Brief   : Directed self-checking bench for shift_sched with a latch+shifter model.
// Revision: 1.0
// ============================================================================
module tb_shift_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, req_left, req_log, req_rot;
  logic [127:0] req_x;
  logic [19:0]  req_s;
  logic [31:0]  sh_x, sh_z, rsp_z;
  logic [4:0]   sh_s;
  logic         sh_left, sh_log, sh_en, rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sched #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_s(req_s), .req_left(req_left), .req_log(req_log), .req_rot(req_rot),
    .sh_x(sh_x), .sh_s(sh_s), .sh_left(sh_left), .sh_log(sh_log), .sh_en(sh_en), .sh_z(sh_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_id(rsp_id)
  );

  // External shifter: transparent input latch while EN, combinational shift after it.
  logic [31:0] m_x;
  logic [4:0]  m_s;
  logic        m_left, m_log;

  always_latch begin
    if (sh_en) begin
      m_x    <= sh_x;
      m_s    <= sh_s;
      m_left <= sh_left;
      m_log  <= sh_log;
    end
  end

  always_comb begin
    if (m_left)     sh_z = m_x << m_s;
    else if (m_log) sh_z = m_x >> m_s;
    else            sh_z = $unsigned($signed(m_x) >>> m_s);
  end

  typedef struct {
    int          id;
    logic [31:0] x;
    logic [4:0]  s;
    logic        left;
    logic        lg;
    logic        rot;
    logic [31:0] z;
    int          lat;
    int          npass;
  } row_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_x = '0; req_s = '0;
    req_left = '0; req_log = '0; req_rot = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (sh_en !== 1'b0) begin errors++; $display("FAIL reset_sh_en got %b exp 0", sh_en); end
    checks++; if (sh_x !== 32'h0) begin errors++; $display("FAIL reset_sh_x got %h exp 0", sh_x); end
    checks++; if ({sh_s, sh_left, sh_log} !== 7'h0) begin errors++; $display("FAIL reset_sh_mode got %b exp 0", {sh_s, sh_left, sh_log}); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_z !== 32'h0) begin errors++; $display("FAIL reset_rsp_z got %h exp 0", rsp_z); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_x[95:64] = 32'h80000001;
    req_s[14:10] = 5'd4;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_pass1 got %b exp 0000", req_ready); end
    checks++; if (sh_en !== 1'b1) begin errors++; $display("FAIL single_sh_en got %b exp 1", sh_en); end
    checks++; if ({sh_x, sh_s, sh_left, sh_log} !== {32'h80000001, 5'd4, 1'b0, 1'b0}) begin
      errors++; $display("FAIL single_sh_drive got %h/%0d/%b/%b exp 80000001/4/0/0", sh_x, sh_s, sh_left, sh_log);
    end
    tick();
    checks++; if (rsp_valid !== 1'b1 || sh_en !== 1'b0) begin errors++; $display("FAIL single_rsp_timing got valid %b en %b exp 1 0", rsp_valid, sh_en); end
    checks++; if (rsp_z !== 32'hF8000000) begin errors++; $display("FAIL single_rsp_z got %h exp f8000000", rsp_z); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id got %0d exp 2", rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got %b exp 0", rsp_valid); end
  endtask

  task automatic test_fairness();
    logic [31:0] xs [4];
    logic [31:0] zs [4];
    int          order [5];
    int          ng, nr, last;
    logic [3:0]  oh;
    xs = '{32'h1, 32'h3, 32'h7, 32'hF};
    zs = '{32'h2, 32'hC, 32'h38, 32'hF0};
    order = '{0, 1, 2, 3, 0};
    ng = 0; nr = 0; last = 0;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_x[i*32 +: 32] = xs[i];
      req_s[i*5 +: 5]   = 5'(i + 1);
    end
    req_left  = 4'b1111;
    req_valid = 4'b1111;
    for (int c = 0; c < 20 && ng < 5; c++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        oh = 4'b0001 << order[ng];
        checks++; if (req_ready !== oh) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", ng, req_ready, oh); end
        if (ng > 0) begin
          checks++; if (c - last !== 3) begin errors++; $display("FAIL fair_spacing%0d got %0d exp 3", ng, c - last); end
        end
        last = c;
        ng++;
      end
      if (rsp_valid === 1'b1 && nr < 4) begin
        checks++; if (rsp_id !== 2'(order[nr]) || rsp_z !== zs[order[nr]]) begin
          errors++; $display("FAIL fair_rsp%0d got id %0d z %h exp id %0d z %h", nr, rsp_id, rsp_z, order[nr], zs[order[nr]]);
        end
        nr++;
      end
      tick();
    end
    checks++; if (ng !== 5 || nr !== 4) begin errors++; $display("FAIL fair_count got grants %0d rsps %0d exp 5 4", ng, nr); end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_x[63:32] = 32'hF0000000;
    req_s[9:5]   = 5'd8;
    req_log      = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_pass1 got %b exp 0000", req_ready); end
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'd1, 32'h00F00000}) begin
        errors++; $display("FAIL bp_hold%0d got v%b id%0d z%h exp v1 id1 z00f00000", k, rsp_valid, rsp_id, rsp_z);
      end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d got %b exp 0000", k, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_at_hs got %b exp 1", rsp_valid); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs got %b exp 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_x[95:64] = 32'hDEADBEEF;
    req_s[14:10] = 5'd3;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    rst = 1'b1;
    #1;
    checks++; if (sh_en !== 1'b1) begin errors++; $display("FAIL mid_in_pass1 got %b exp 1", sh_en); end
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++; if (rsp_valid !== 1'b0 || sh_en !== 1'b0) begin errors++; $display("FAIL mid_idle got valid %b en %b exp 0 0", rsp_valid, sh_en); end
    checks++; if (sh_x !== 32'h0) begin errors++; $display("FAIL mid_operand_clr got %h exp 0", sh_x); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL mid_next_rsp got v%b id%0d exp v1 id0", rsp_valid, rsp_id); end
    tick();
  endtask

  task automatic test_modes();
    row_t rows[$];
    rows.push_back('{0, 32'h80000001, 5'd4,  1'b0, 1'b1, 1'b0, 32'h08000000, 2, 1});
    rows.push_back('{3, 32'h00000001, 5'd31, 1'b1, 1'b0, 1'b0, 32'h80000000, 2, 1});
    rows.push_back('{1, 32'h8000F000, 5'd0,  1'b0, 1'b0, 1'b0, 32'h8000F000, 2, 1});
    rows.push_back('{2, 32'h7FFFFFFF, 5'd31, 1'b0, 1'b0, 1'b0, 32'h00000000, 2, 1});
    rows.push_back('{2, 32'hFFFFFFFF, 5'd31, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 2, 1});
`ifdef SHIFT_SCHED_ROTATE_EN
    rows.push_back('{0, 32'h12345678, 5'd8,  1'b1, 1'b0, 1'b1, 32'h34567812, 3, 2});
    rows.push_back('{1, 32'h12345678, 5'd0,  1'b1, 1'b0, 1'b1, 32'h12345678, 2, 1});
    rows.push_back('{3, 32'h80000001, 5'd4,  1'b0, 1'b0, 1'b1, 32'h18000000, 3, 2});
`else
    rows.push_back('{0, 32'h12345678, 5'd8,  1'b1, 1'b0, 1'b1, 32'h34567800, 2, 1});
`endif
    do_reset();
    foreach (rows[n]) begin
      int         cyc;
      int         passes;
      bit         seen;
      logic [3:0] oh;
      cyc = 0; passes = 0; seen = 1'b0;
      clear_inputs();
      rsp_ready = 1'b1;
      req_valid[rows[n].id]       = 1'b1;
      req_x[rows[n].id*32 +: 32]  = rows[n].x;
      req_s[rows[n].id*5 +: 5]    = rows[n].s;
      req_left[rows[n].id]        = rows[n].left;
      req_log[rows[n].id]         = rows[n].lg;
      req_rot[rows[n].id]         = rows[n].rot;
      oh = 4'b0001 << rows[n].id;
      #1;
      checks++; if (req_ready !== oh) begin errors++; $display("FAIL mode%0d_grant got %b exp %b", n, req_ready, oh); end
      tick();
      req_valid = '0;
      for (int k = 1; k <= 8 && !seen; k++) begin
        #1;
        if (sh_en === 1'b1) passes++;
        if (rsp_valid === 1'b1) begin
          seen = 1'b1;
          cyc  = k;
        end else begin
          tick();
        end
      end
      checks++; if (cyc !== rows[n].lat) begin errors++; $display("FAIL mode%0d_latency got %0d exp %0d", n, cyc, rows[n].lat); end
      checks++; if (passes !== rows[n].npass) begin errors++; $display("FAIL mode%0d_passes got %0d exp %0d", n, passes, rows[n].npass); end
      checks++; if (rsp_z !== rows[n].z || rsp_id !== 2'(rows[n].id)) begin
        errors++; $display("FAIL mode%0d_result got z %h id %0d exp z %h id %0d", n, rsp_z, rsp_id, rows[n].z, rows[n].id);
      end
      tick();
    end
  endtask

  task automatic test_rotate_passes();
    do_reset();
    rsp_ready    = 1'b1;
    req_valid    = 4'b0001;
    req_x[31:0]  = 32'h12345678;
    req_s[4:0]   = 5'd8;
    req_left     = 4'b0001;
    req_rot      = 4'b0001;
    tick();
    req_valid = '0;
    #1;
`ifdef SHIFT_SCHED_ROTATE_EN
    checks++; if ({sh_en, sh_s, sh_left, sh_log} !== {1'b1, 5'd8, 1'b1, 1'b1}) begin
      errors++; $display("FAIL rot_pass1 got en%b s%0d l%b g%b exp en1 s8 l1 g1", sh_en, sh_s, sh_left, sh_log);
    end
    tick();
    checks++; if ({sh_en, sh_s, sh_left, sh_log} !== {1'b1, 5'd24, 1'b0, 1'b1} || sh_x !== 32'h12345678) begin
      errors++; $display("FAIL rot_pass2 got en%b s%0d l%b g%b x%h exp en1 s24 l0 g1 x12345678", sh_en, sh_s, sh_left, sh_log, sh_x);
    end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_z !== 32'h34567812) begin
      errors++; $display("FAIL rot_result got v%b z%h exp v1 z34567812", rsp_valid, rsp_z);
    end
`else
    checks++; if ({sh_en, sh_s, sh_left, sh_log} !== {1'b1, 5'd8, 1'b1, 1'b0}) begin
      errors++; $display("FAIL norot_pass1 got en%b s%0d l%b g%b exp en1 s8 l1 g0", sh_en, sh_s, sh_left, sh_log);
    end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_z !== 32'h34567800) begin
      errors++; $display("FAIL norot_result got v%b z%h exp v1 z34567800", rsp_valid, rsp_z);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_modes();
    test_rotate_passes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got no finish exp finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
